lsu: RTL and testbench
======================

# lsu

Load/store unit for the RISC-V single-cycle datapath's multi-cycle memory path. It sits directly downstream of the ALU: it takes the effective address (ALU result), store data (rs2) and funct3, and turns them into word-aligned data-memory transactions with byte enables. It waits on a request/grant/response handshake, then returns sign- or zero-extended load data for register writeback. It also flags misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT, 16, maximum cycles spent in REQ or in WAIT before a timeout fault; legal range ≥1
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  execute stage presents an access
- o_ready  out  1  LSU idle; access accepted when i_valid && o_ready
- i_addr  in  32  effective byte address (ALU result)
- i_wdata  in  32  store data (rs2)
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- i_we  in  1  1 = store, 0 = load
- i_rd_addr  in  5  load destination register
- o_done  out  1  one-cycle pulse, access finished (success or fault)
- o_wb_valid  out  1  one-cycle pulse with o_done on a successful load
- o_wb_rd_addr  out  5  destination of the finished load
- o_wb_data  out  32  extended load data
- o_fault  out  1  pulse with o_done on a fault
- o_fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
- o_mem_req  out  1  memory request
- i_mem_gnt  in  1  memory accepts request this cycle
- o_mem_addr  out  32  {i_addr[31:2], 2'b00}
- o_mem_we  out  1  store request
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_rvalid  in  1  read data valid; never earlier than the cycle after gnt
- i_mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. o_ready = (state == IDLE).
- IDLE: on acceptance, register all i_* inputs and check the access:
  - Illegal funct3: 011/110/111, or a store with funct3[2]=1. Next state RESP with cause 10.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Next state RESP with cause 01. Illegal takes priority over misaligned.
  - Otherwise next state REQ.
- REQ: o_mem_req=1, with address, we, be and wdata held stable.
  - On i_mem_gnt: a store goes to RESP; a load goes to WAIT.
- WAIT: on i_mem_rvalid, latch the extracted data and go to RESP.
- RESP: o_done=1 for exactly one cycle. Asserts o_wb_valid for a successful load, or o_fault with its cause. Next state IDLE.
- Byte enables and store data:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
- Load extraction:
  - Byte lane = rdata[8*addr[1:0] +: 8].
  - Half lane = addr[1] ? rdata[31:16] : rdata[15:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Timeout: a counter clears on entry to REQ and to WAIT and increments each cycle in those states. If it reaches TIMEOUT without gnt (in REQ) or rvalid (in WAIT), go to RESP with cause 11 and drop o_mem_req.
- i_mem_rvalid is ignored outside WAIT. i_valid is ignored outside IDLE.
- A store never asserts o_wb_valid. A faulted access never asserts o_mem_req.

## Timing
- Reset (any state): next edge goes to IDLE and clears the timeout counter.
  - Reset values: o_ready=1; o_done, o_wb_valid, o_fault, o_mem_req, o_mem_we = 0; o_fault_cause=00; o_mem_be=0; o_wb_data, o_wb_rd_addr, o_mem_addr, o_mem_wdata = 0.
  - Reset mid-transaction abandons the access. A late rvalid after reset is ignored.
- All outputs are registered or decoded from state. There is no combinational path from i_mem_* to o_mem_req.
- Zero-wait load, accepted at edge T:
  - REQ in cycle T+1 (gnt sampled), WAIT in T+2 (rvalid sampled).
  - RESP in T+3, with o_wb_valid/o_wb_data valid.
  - o_ready high again in T+4.
- Zero-wait store: REQ in T+1, RESP in T+2, o_ready in T+3.
- Fault at acceptance: RESP in T+1, o_ready in T+2.
- Each gnt wait cycle adds one cycle; each rvalid wait cycle adds one cycle.
- Timeout: with no gnt, RESP occurs TIMEOUT cycles after REQ entry.

## Test plan
- LW at 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF: o_mem_addr=0x100, be=1111, wb_data=0xDEADBEEF, rd echoed, o_wb_valid at T+3.
- LB at 0x103 and LBU at 0x103, rdata 0x80112233: wb_data=0xFFFFFF80 and 0x00000080. LH at 0x102: 0xFFFF8011. LHU at 0x102: 0x00008011.
- SB at 0x201 with wdata 0x000000AB, gnt after 3 wait cycles: o_mem_req held 4 cycles, addr=0x200, be=0010, wdata=0xABABABAB, o_done without o_wb_valid.
- SH at 0x203: o_fault cause 01 at T+1, no o_mem_req. Store with funct3=100: cause 10.
- LW with gnt but no rvalid, TIMEOUT=16: cause 11 exactly 16 cycles after WAIT entry. A later rvalid is ignored and the next access works.
- Assert i_rst while in WAIT: next cycle IDLE, o_ready=1, all pulses 0. A stray rvalid produces no o_wb_valid.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus funct3 into a word-aligned
// request/grant/response memory transaction and returns extended load data or a fault.
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  output logic        o_done,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd_addr,
  output logic [31:0] o_wb_data,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // The counter only has to reach TIMEOUT-1; the final count cycle decides the timeout.
  localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [3:0]    be_q, be_d;
  logic [1:0]    cause_q, cause_d;

  logic          illegal_s;
  logic          misaligned_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_rep_s;

  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'h000000, b};
      3'b101:  extract = {16'h0000, h};
      default: extract = rdata;
    endcase
  endfunction

  always_comb begin
    illegal_s    = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                   (i_funct3 == 3'b111) || (i_we && i_funct3[2]);
    misaligned_s = 1'b0;
    be_s         = 4'b1111;
    wdata_rep_s  = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        be_s        = 4'b0001 << i_addr[1:0];
        wdata_rep_s = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        misaligned_s = i_addr[0];
        be_s         = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep_s  = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        misaligned_s = (i_addr[1:0] != 2'b00);
      end
      default: begin
        misaligned_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    rd_d      = rd_q;
    be_d      = be_q;
    cause_d   = cause_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          addr_d   = i_addr;
          wdata_d  = wdata_rep_s;
          funct3_d = i_funct3;
          we_d     = i_we;
          rd_d     = i_rd_addr;
          be_d     = be_s;
          cnt_d    = {CW{1'b0}};
          // Illegal encodings outrank misalignment.
          if (illegal_s) begin
            cause_d = CAUSE_ILL;
            state_d = S_RESP;
          end else if (misaligned_s) begin
            cause_d = CAUSE_MIS;
            state_d = S_RESP;
          end else begin
            cause_d = CAUSE_NONE;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          cnt_d   = {CW{1'b0}};
          state_d = we_q ? S_RESP : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = CAUSE_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          wb_data_d = extract(i_mem_rdata, addr_q[1:0], funct3_q);
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = CAUSE_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wb_data_q <= 32'h0000_0000;
      funct3_q  <= 3'b000;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      be_q      <= 4'b0000;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      funct3_q  <= funct3_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      be_q      <= be_d;
      cause_q   <= cause_d;
    end
  end

  // Outputs come from flops or a state decode only; no i_mem_* path reaches them.
  assign o_ready       = (state_q == S_IDLE);
  assign o_done        = (state_q == S_RESP);
  assign o_wb_valid    = (state_q == S_RESP) && !we_q && (cause_q == CAUSE_NONE);
  assign o_fault       = (state_q == S_RESP) && (cause_q != CAUSE_NONE);
  assign o_fault_cause = (state_q == S_RESP) ? cause_q : CAUSE_NONE;
  assign o_wb_rd_addr  = rd_q;
  assign o_wb_data     = wb_data_q;
  assign o_mem_req     = (state_q == S_REQ);
  assign o_mem_addr    = {addr_q[31:2], 2'b00};
  assign o_mem_we      = we_q;
  assign o_mem_be      = be_q;
  assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a memory responder with programmable grant/rvalid
// delays and a queue of expected responses compared when o_done pulses.
module tb_lsu;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_we, i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd_addr;
  logic        o_ready, o_done, o_wb_valid, o_fault, o_mem_req, o_mem_we;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_data, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_fault_cause;
  logic [3:0]  o_mem_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wb;
    logic [1:0]  cause;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
    int          reqc;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mwe;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_funct3(i_funct3), .i_we(i_we),
    .i_rd_addr(i_rd_addr), .o_done(o_done), .o_wb_valid(o_wb_valid),
    .o_wb_rd_addr(o_wb_rd_addr), .o_wb_data(o_wb_data), .o_fault(o_fault),
    .o_fault_cause(o_fault_cause), .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  function automatic exp_t mk(input logic wb, input logic [1:0] cause, input logic [4:0] rd,
                              input logic [31:0] data, input int lat, input int reqc,
                              input logic [31:0] maddr, input logic [3:0] be,
                              input logic [31:0] mwdata, input logic mwe);
    exp_t e;
    e.wb = wb; e.cause = cause; e.rd = rd; e.data = data; e.lat = lat; e.reqc = reqc;
    e.maddr = maddr; e.be = be; e.mwdata = mwdata; e.mwe = mwe;
    return e;
  endfunction

  // Issue one access, act as memory (gnt after gnt_wait extra cycles, rvalid rv_wait
  // cycles after the earliest legal cycle; negative = never), then check the response.
  task automatic access(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
    int c = 0, req_cnt = 0, gnt_c = -1;
    logic done = 1'b0;
    logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0, cap_wb_data = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic        cap_we = 1'b0, cap_wbv = 1'b0, cap_flt = 1'b0;
    logic [1:0]  cap_cause = 2'b00;
    logic [4:0]  cap_rd = 5'd0;
    exp_t e;
    @(negedge clk);
    i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    i_rd_addr = rd; i_mem_rdata = rdata;
    @(posedge clk);
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      i_valid = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      if (o_mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          cap_addr = o_mem_addr; cap_be = o_mem_be; cap_wdata = o_mem_wdata; cap_we = o_mem_we;
        end
        if (gnt_wait >= 0 && req_cnt == gnt_wait + 1) begin
          i_mem_gnt = 1'b1; gnt_c = c;
        end
      end
      if (gnt_c >= 0 && rv_wait >= 0 && c == gnt_c + 1 + rv_wait) i_mem_rvalid = 1'b1;
      if (o_done) begin
        done = 1'b1;
        cap_wbv = o_wb_valid; cap_flt = o_fault; cap_cause = o_fault_cause;
        cap_rd = o_wb_rd_addr; cap_wb_data = o_wb_data;
      end
    end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s done_timeout: no o_done within %0d cycles", name, c);
    end else begin
      checks++;
      if (c !== e.lat) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, c, e.lat); end
      checks++;
      if (cap_wbv !== e.wb) begin errors++; $display("FAIL %s wb_valid: got %b exp %b", name, cap_wbv, e.wb); end
      checks++;
      if (cap_flt !== (e.cause != 2'b00)) begin errors++; $display("FAIL %s fault: got %b exp %b", name, cap_flt, (e.cause != 2'b00)); end
      checks++;
      if (cap_cause !== e.cause) begin errors++; $display("FAIL %s cause: got %b exp %b", name, cap_cause, e.cause); end
      if (e.wb) begin
        checks++;
        if (cap_rd !== e.rd) begin errors++; $display("FAIL %s rd: got %0d exp %0d", name, cap_rd, e.rd); end
        checks++;
        if (cap_wb_data !== e.data) begin errors++; $display("FAIL %s wb_data: got %h exp %h", name, cap_wb_data, e.data); end
      end
    end
    checks++;
    if (req_cnt !== e.reqc) begin errors++; $display("FAIL %s req_cycles: got %0d exp %0d", name, req_cnt, e.reqc); end
    if (e.reqc > 0) begin
      checks++;
      if (cap_addr !== e.maddr) begin errors++; $display("FAIL %s mem_addr: got %h exp %h", name, cap_addr, e.maddr); end
      checks++;
      if (cap_be !== e.be) begin errors++; $display("FAIL %s mem_be: got %b exp %b", name, cap_be, e.be); end
      checks++;
      if (cap_we !== e.mwe) begin errors++; $display("FAIL %s mem_we: got %b exp %b", name, cap_we, e.mwe); end
      if (e.mwe) begin
        checks++;
        if (cap_wdata !== e.mwdata) begin errors++; $display("FAIL %s mem_wdata: got %h exp %h", name, cap_wdata, e.mwdata); end
      end
    end
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL %s ready_after: got ready=%b done=%b exp ready=1 done=0", name, o_ready, o_done);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b exp 1", o_ready); end
    checks++;
    if ({o_done, o_wb_valid, o_fault, o_mem_req, o_mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset pulses: got %b exp 00000", {o_done, o_wb_valid, o_fault, o_mem_req, o_mem_we});
    end
    checks++;
    if ({o_fault_cause, o_mem_be, o_wb_rd_addr} !== 11'b0) begin
      errors++; $display("FAIL reset cause_be_rd: got %h exp 0", {o_fault_cause, o_mem_be, o_wb_rd_addr});
    end
    checks++;
    if ({o_wb_data, o_mem_addr, o_mem_wdata} !== 96'b0) begin
      errors++; $display("FAIL reset data_addr: got %h exp 0", {o_wb_data, o_mem_addr, o_mem_wdata});
    end
    i_rst = 1'b0;
  endtask

  task automatic test_loads();
    sb.push_back(mk(1'b1, 2'b00, 5'd5, 32'hDEADBEEF, 3, 1, 32'h100, 4'b1111, 32'h0, 1'b0));
    access("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);
    sb.push_back(mk(1'b1, 2'b00, 5'd7, 32'hFFFFFF80, 3, 1, 32'h100, 4'b1000, 32'h0, 1'b0));
    access("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80112233);
    sb.push_back(mk(1'b1, 2'b00, 5'd8, 32'h00000080, 3, 1, 32'h100, 4'b1000, 32'h0, 1'b0));
    access("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 0, 0, 32'h80112233);
    sb.push_back(mk(1'b1, 2'b00, 5'd9, 32'hFFFF8011, 3, 1, 32'h100, 4'b1100, 32'h0, 1'b0));
    access("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 5'd9, 0, 0, 32'h80112233);
    sb.push_back(mk(1'b1, 2'b00, 5'd10, 32'h00008011, 3, 1, 32'h100, 4'b1100, 32'h0, 1'b0));
    access("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 5'd10, 0, 0, 32'h80112233);
    sb.push_back(mk(1'b1, 2'b00, 5'd11, 32'h00000022, 3, 1, 32'h100, 4'b0010, 32'h0, 1'b0));
    access("lb_101", 1'b0, 3'b000, 32'h101, 32'h0, 5'd11, 0, 0, 32'h80112233);
    sb.push_back(mk(1'b1, 2'b00, 5'd12, 32'h00002233, 3, 1, 32'h100, 4'b0011, 32'h0, 1'b0));
    access("lh_100", 1'b0, 3'b001, 32'h100, 32'h0, 5'd12, 0, 0, 32'h80112233);
    sb.push_back(mk(1'b1, 2'b00, 5'd31, 32'h0BADF00D, 8, 3, 32'h4440, 4'b1111, 32'h0, 1'b0));
    access("lw_wait", 1'b0, 3'b010, 32'h4440, 32'h0, 5'd31, 2, 3, 32'h0BADF00D);
  endtask

  task automatic test_stores();
    sb.push_back(mk(1'b0, 2'b00, 5'd3, 32'h0, 5, 4, 32'h200, 4'b0010, 32'hABABABAB, 1'b1));
    access("sb_201", 1'b1, 3'b000, 32'h201, 32'h000000AB, 5'd3, 3, -1, 32'h0);
    sb.push_back(mk(1'b0, 2'b00, 5'd4, 32'h0, 2, 1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1));
    access("sh_202", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd4, 0, -1, 32'h0);
    sb.push_back(mk(1'b0, 2'b00, 5'd6, 32'h0, 3, 2, 32'h300, 4'b1111, 32'h12345678, 1'b1));
    access("sw_300", 1'b1, 3'b010, 32'h300, 32'h12345678, 5'd6, 1, -1, 32'h0);
  endtask

  task automatic test_faults();
    sb.push_back(mk(1'b0, 2'b01, 5'd1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0));
    access("sh_203_mis", 1'b1, 3'b001, 32'h203, 32'h0, 5'd1, 0, 0, 32'h0);
    sb.push_back(mk(1'b0, 2'b10, 5'd1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0));
    access("st_f3_100_ill", 1'b1, 3'b100, 32'h200, 32'h0, 5'd1, 0, 0, 32'h0);
    sb.push_back(mk(1'b0, 2'b01, 5'd2, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0));
    access("lw_102_mis", 1'b0, 3'b010, 32'h102, 32'h0, 5'd2, 0, 0, 32'h0);
    sb.push_back(mk(1'b0, 2'b10, 5'd2, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0));
    access("ld_f3_011_ill", 1'b0, 3'b011, 32'h100, 32'h0, 5'd2, 0, 0, 32'h0);
    sb.push_back(mk(1'b0, 2'b10, 5'd2, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0));
    access("ill_over_mis", 1'b0, 3'b111, 32'h103, 32'h0, 5'd2, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    sb.push_back(mk(1'b0, 2'b11, 5'd13, 32'h0, 18, 1, 32'h500, 4'b1111, 32'h0, 1'b0));
    access("wait_timeout", 1'b0, 3'b010, 32'h500, 32'h0, 5'd13, 0, -1, 32'h11111111);
    i_mem_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_wb_valid !== 1'b0) begin
        errors++; $display("FAIL late_rvalid: got done=%b wb_valid=%b exp 0 0", o_done, o_wb_valid);
      end
    end
    i_mem_rvalid = 1'b0;
    sb.push_back(mk(1'b0, 2'b11, 5'd14, 32'h0, 17, 16, 32'h600, 4'b1111, 32'h0, 1'b0));
    access("req_timeout", 1'b0, 3'b010, 32'h600, 32'h0, 5'd14, -1, -1, 32'h0);
    sb.push_back(mk(1'b1, 2'b00, 5'd15, 32'hCAFEF00D, 3, 1, 32'h700, 4'b1111, 32'h0, 1'b0));
    access("after_timeout", 1'b0, 3'b010, 32'h700, 32'h0, 5'd15, 0, 0, 32'hCAFEF00D);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h800; i_rd_addr = 5'd20;
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_mem_req !== 1'b1) begin errors++; $display("FAIL rst_wait req: got %b exp 1", o_mem_req); end
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_wait ready: got %b exp 1", o_ready); end
    checks++;
    if ({o_done, o_wb_valid, o_fault, o_mem_req} !== 4'b0) begin
      errors++; $display("FAIL rst_wait pulses: got %b exp 0000", {o_done, o_wb_valid, o_fault, o_mem_req});
    end
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_done !== 1'b0 || o_wb_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++; $display("FAIL stray_rvalid: got done=%b wb_valid=%b ready=%b exp 0 0 1", o_done, o_wb_valid, o_ready);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_addr = 32'h0; i_wdata = 32'h0; i_mem_rdata = 32'h0; i_funct3 = 3'b000; i_rd_addr = 5'd0;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
